// File: rtl/dmem_pkg.sv
// Shared decode constants and types for the CPU data-memory responder.
package dmem_pkg;
    localparam logic [3:0] OFF_CYCLE   = 4'h0;
    localparam logic [3:0] OFF_CONSOLE = 4'h4;
    localparam logic [3:0] OFF_STATUS  = 4'h8;

    localparam int ST_OVF   = 5;
    localparam int ST_FULL  = 4;
    localparam int ST_EMPTY = 3;

    typedef enum logic [1:0] {SEL_RAM, SEL_MMIO, SEL_NONE} sel_e;
endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is accepted only when a pop frees a slot that cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     dropped
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    // a pop on an empty FIFO is ignored, so a same-cycle push still lands
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dropped = push & full & ~do_pop;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/dmem_responder.sv
// CPU data-port responder: word RAM plus an MMIO window with a cycle counter and console FIFO.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH      = 2048,
    parameter logic [31:0] DATA_BASE  = 32'h1001_0000,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        DM_ena,
    input  logic        DM_R,
    input  logic        DM_W,
    output logic [31:0] rdata,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        err
);
    localparam int          AW        = $clog2(DEPTH);
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);

    logic [31:0]   ram [DEPTH];
    logic [31:0]   counter;
    logic          overflow;
    logic [31:0]   ram_off;
    logic [AW-1:0] ram_idx;
    sel_e          sel;
    logic          rd_en, wr_en, bad;
    logic          mmio_wr, cyc_wr, push, stat_wr;
    logic          fifo_full, fifo_empty, fifo_drop;
    logic [CW-1:0] fifo_count;
    logic [2:0]    cnt3;
    logic [31:0]   status;

    // unsigned subtract folds both range bounds into one compare
    assign ram_off = addr - DATA_BASE;
    assign ram_idx = ram_off[AW+1:2];

    always_comb begin
        sel = SEL_NONE;
        if (addr[1:0] == 2'b00) begin
            if (ram_off < RAM_BYTES)                  sel = SEL_RAM;
            else if (addr[31:4] == MMIO_BASE[31:4])   sel = SEL_MMIO;
        end
    end

    assign rd_en   = DM_ena & DM_R & ~DM_W;
    assign wr_en   = DM_ena & DM_W;
    assign bad     = DM_ena & (DM_R | DM_W) & (sel == SEL_NONE);
    assign mmio_wr = wr_en & (sel == SEL_MMIO);
    assign cyc_wr  = mmio_wr & (addr[3:0] == OFF_CYCLE);
    assign push    = mmio_wr & (addr[3:0] == OFF_CONSOLE);
    assign stat_wr = mmio_wr & (addr[3:0] == OFF_STATUS);

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_console (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (wdata[7:0]),
        .pop       (out_ready),
        .head      (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .dropped   (fifo_drop)
    );

    assign out_valid = ~fifo_empty;
    assign cnt3      = 3'(fifo_count);

    always_comb begin
        status           = '0;
        status[ST_OVF]   = overflow;
        status[ST_FULL]  = fifo_full;
        status[ST_EMPTY] = fifo_empty;
        status[2:0]      = cnt3;
    end

    always_comb begin
        rdata = '0;
        if (rd_en) begin
            case (sel)
                SEL_RAM:  rdata = ram[ram_idx];
                SEL_MMIO: begin
                    case (addr[3:0])
                        OFF_CYCLE:  rdata = counter;
                        OFF_STATUS: rdata = status;
                        default:    rdata = '0;
                    endcase
                end
                default:  rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && sel == SEL_RAM) ram[ram_idx] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter  <= '0;
            overflow <= 1'b0;
            err      <= 1'b0;
        end else begin
            counter <= cyc_wr ? wdata : counter + 32'd1;
            if (fifo_drop)    overflow <= 1'b1;
            else if (stat_wr) overflow <= 1'b0;
            if (bad) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM, cycle counter, console FIFO, decode errors.
module tb_dmem_responder;
    localparam logic [31:0] A_CYC  = 32'hFFFF_0000;
    localparam logic [31:0] A_CON  = 32'hFFFF_0004;
    localparam logic [31:0] A_STAT = 32'hFFFF_0008;
    localparam logic [31:0] A_RSV  = 32'hFFFF_000C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0, wdata = '0;
    logic        DM_ena = 1'b0, DM_R = 1'b0, DM_W = 1'b0;
    logic [31:0] rdata;
    logic        out_valid, out_ready = 1'b0, err;
    logic [7:0]  out_data;

    int checks = 0;
    int fails  = 0;

    dmem_responder dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata),
        .DM_ena(DM_ena), .DM_R(DM_R), .DM_W(DM_W), .rdata(rdata),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; DM_ena = 1'b1; DM_W = 1'b1; DM_R = 1'b0;
        @(posedge clk); #1;
        DM_ena = 1'b0; DM_W = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        @(negedge clk);
        addr = a; DM_ena = 1'b1; DM_R = 1'b1; DM_W = 1'b0;
        #1;
    endtask

    task automatic bus_idle();
        DM_ena = 1'b0; DM_R = 1'b0; DM_W = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin fails++; $display("FAIL rst_out_data: got %h expected 00", out_data); end
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b expected 0", err); end
        rd(A_STAT);
        checks++; if (rdata !== 32'h0000_0008) begin fails++; $display("FAIL rst_status: got %h expected 00000008", rdata); end
        rd(A_CYC);
        checks++; if (rdata !== 32'h0) begin fails++; $display("FAIL rst_cycle: got %h expected 00000000", rdata); end
        rst = 1'b0;
        rd(A_CYC);
        checks++; if (rdata !== 32'h1) begin fails++; $display("FAIL cycle_first_inc: got %h expected 00000001", rdata); end
        bus_idle();
    endtask

    task automatic test_ram();
        wr(32'h1001_0004, 32'hDEAD_BEEF);
        rd(32'h1001_0004);
        checks++; if (rdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL ram_read: got %h expected deadbeef", rdata); end
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL ram_err: got %b expected 0", err); end
        // read and write strobes together act as a write with zero read data
        @(negedge clk);
        addr = 32'h1001_0008; wdata = 32'h1234_5678; DM_ena = 1'b1; DM_R = 1'b1; DM_W = 1'b1;
        #1;
        checks++; if (rdata !== 32'h0) begin fails++; $display("FAIL rw_both_rdata: got %h expected 00000000", rdata); end
        @(posedge clk); #1;
        bus_idle();
        rd(32'h1001_0008);
        checks++; if (rdata !== 32'h1234_5678) begin fails++; $display("FAIL rw_both_write: got %h expected 12345678", rdata); end
        wr(32'h1001_1FFC, 32'hCAFE_F00D);
        rd(32'h1001_1FFC);
        checks++; if (rdata !== 32'hCAFE_F00D) begin fails++; $display("FAIL ram_last_word: got %h expected cafef00d", rdata); end
        rd(32'h1001_0000);
        DM_ena = 1'b0;
        #1;
        checks++; if (rdata !== 32'h0) begin fails++; $display("FAIL rdata_disabled: got %h expected 00000000", rdata); end
        rd(A_RSV);
        checks++; if (rdata !== 32'h0) begin fails++; $display("FAIL reserved_read: got %h expected 00000000", rdata); end
        rd(A_CON);
        checks++; if (rdata !== 32'h0) begin fails++; $display("FAIL console_read: got %h expected 00000000", rdata); end
        bus_idle();
    endtask

    task automatic test_fifo_overflow();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr(A_CON, 32'h41 + 32'(i));
        rd(A_STAT);
        checks++; if (rdata !== 32'h0000_0034) begin fails++; $display("FAIL ovf_status: got %h expected 00000034", rdata); end
        checks++; if (out_data !== 8'h41) begin fails++; $display("FAIL ovf_head: got %h expected 41", out_data); end
        checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL ovf_valid: got %b expected 1", out_valid); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(8'h41 + i)) begin
                fails++; $display("FAIL drain_%0d: got valid=%b data=%h expected valid=1 data=%h", i, out_valid, out_data, 8'(8'h41 + i));
            end
            @(posedge clk); #1;
        end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL drain_empty: got %b expected 0", out_valid); end
        out_ready = 1'b0;
        rd(A_STAT);
        checks++; if (rdata !== 32'h0000_0028) begin fails++; $display("FAIL drained_status: got %h expected 00000028", rdata); end
        wr(A_STAT, 32'h0);
        rd(A_STAT);
        checks++; if (rdata !== 32'h0000_0008) begin fails++; $display("FAIL ovf_clear: got %h expected 00000008", rdata); end
        bus_idle();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) wr(A_CON, 32'h51 + 32'(i));
        @(negedge clk);
        addr = A_CON; wdata = 32'h55; DM_ena = 1'b1; DM_W = 1'b1; DM_R = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        bus_idle(); out_ready = 1'b0;
        checks++; if (out_data !== 8'h52) begin fails++; $display("FAIL full_pushpop_head: got %h expected 52", out_data); end
        rd(A_STAT);
        checks++; if (rdata !== 32'h0000_0014) begin fails++; $display("FAIL full_pushpop_status: got %h expected 00000014", rdata); end
        bus_idle();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(8'h52 + i)) begin
                fails++; $display("FAIL tail_drain_%0d: got valid=%b data=%h expected valid=1 data=%h", i, out_valid, out_data, 8'(8'h52 + i));
            end
            @(posedge clk); #1;
        end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL tail_empty: got %b expected 0", out_valid); end
        // empty FIFO: simultaneous pop is ignored and the byte lands
        @(negedge clk);
        addr = A_CON; wdata = 32'h66; DM_ena = 1'b1; DM_W = 1'b1;
        @(posedge clk); #1;
        bus_idle(); out_ready = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h66) begin fails++; $display("FAIL empty_pushpop: got valid=%b data=%h expected valid=1 data=66", out_valid, out_data); end
        rd(A_STAT);
        checks++; if (rdata !== 32'h0000_0001) begin fails++; $display("FAIL empty_pushpop_status: got %h expected 00000001", rdata); end
        bus_idle();
    endtask

    task automatic test_counter_wrap();
        wr(A_CYC, 32'hFFFF_FFFE);
        repeat (3) @(posedge clk);
        rd(A_CYC);
        checks++; if (rdata !== 32'h0000_0001) begin fails++; $display("FAIL cycle_wrap: got %h expected 00000001", rdata); end
        bus_idle();
    endtask

    task automatic test_errors();
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL err_before: got %b expected 0", err); end
        rd(32'h1001_0002);
        checks++; if (rdata !== 32'h0) begin fails++; $display("FAIL misaligned_rdata: got %h expected 00000000", rdata); end
        @(posedge clk); #1;
        bus_idle();
        checks++; if (err !== 1'b1) begin fails++; $display("FAIL misaligned_err: got %b expected 1", err); end
        wr(32'h0000_0000, 32'h1111_1111);
        wr(32'h1001_0006, 32'h2222_2222);
        wr(32'h1001_2000, 32'h3333_3333);
        rd(32'h1001_0004);
        checks++; if (rdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL ram_unchanged: got %h expected deadbeef", rdata); end
        rd(32'h1000_FFFC);
        checks++; if (rdata !== 32'h0) begin fails++; $display("FAIL below_base_rdata: got %h expected 00000000", rdata); end
        bus_idle();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (err !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b expected 1", err); end
    endtask

    task automatic test_reset_mid();
        wr(A_CON, 32'h77);
        wr(A_CON, 32'h78);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL midrst_err: got %b expected 0", err); end
        rd(A_STAT);
        checks++; if (rdata !== 32'h0000_0008) begin fails++; $display("FAIL midrst_status: got %h expected 00000008", rdata); end
        rd(32'h1001_0004);
        checks++; if (rdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL midrst_ram: got %h expected deadbeef", rdata); end
        bus_idle();
    endtask

    initial begin
        test_reset();
        test_ram();
        test_fifo_overflow();
        test_back_to_back();
        test_counter_wrap();
        test_errors();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
